inst_sequencer: RTL

- Multi-cycle control sequencer for the 26-bit instruction datapath.
- Fetches each instruction over an instruction-memory handshake and latches it for the instruction decoder.
- Steps through decode, execute, memory and writeback according to the instruction class (inst[25:24]), issuing enables to the ALU, data memory and register file.
- Owns the program counter and a memory-handshake timeout fault.

---
 rtl/inst_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Multi-cycle control sequencer for the 26-bit instruction datapath.
// Fetches over an instruction-memory handshake, then steps DECODE/EXEC/MEM/WB by
// instruction class (inst[25:24]), owns the PC and a sticky memory-timeout fault.
// Optional build macro: INST_SEQ_PERF_EN adds the retired_cnt[31:0] output.
module inst_sequencer #(
  parameter int unsigned PC_W        = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [25:0]     imem_rdata,
  output logic [25:0]     inst_q,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            alu_en,
  output logic            rf_we,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            fault
`ifdef INST_SEQ_PERF_EN
  ,
  output logic [31:0]     retired_cnt
`endif
);

  // Wide enough to hold MEM_TIMEOUT; a 1-bit dummy when the timeout is disabled.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StFault  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ClsAlu    = 2'b00,
    ClsMem    = 2'b01,
    ClsMove   = 2'b10,
    ClsBranch = 2'b11
  } inst_cls_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [25:0]       inst_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [WaitW-1:0]  wait_inc;
  logic              wait_hit;
  logic [PC_W-1:0]   pc_inc;
  inst_cls_e         cls;

  assign cls    = inst_cls_e'(inst_q[25:24]);
  assign pc_inc = pc_q + PC_W'(1);

  // Timeout bookkeeping: the cycle that would make the wait count reach MEM_TIMEOUT
  // faults unless an ack arrives in that same cycle (checked first in the FSM).
  always_comb begin
    wait_inc = wait_q;
    wait_hit = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      wait_inc = wait_q + WaitW'(1);
      wait_hit = ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT);
    end
  end

  // Next-state, PC and instruction-latch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        wait_d  = '0;
      end
      StFetch: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = StDecode;
        end else if (wait_hit) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc;
        end
      end
      StDecode: begin
        if (cls == ClsMove) state_d = StWb;
        else                state_d = StExec;
      end
      StExec: begin
        unique case (cls)
          ClsAlu:  state_d = StWb;
          ClsMem: begin
            state_d = StMem;
            wait_d  = '0;
          end
          ClsBranch: begin
            pc_d    = br_taken ? br_target : pc_inc;
            state_d = StFetch;
            wait_d  = '0;
          end
          ClsMove: state_d = StWb;
        endcase
      end
      StMem: begin
        if (dmem_ack) begin
          if (inst_q[22]) begin
            pc_d    = pc_inc;
            state_d = StFetch;
            wait_d  = '0;
          end else begin
            state_d = StWb;
          end
        end else if (wait_hit) begin
          state_d = StFault;
        end else begin
          wait_d = wait_inc;
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
        wait_d  = '0;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        // Unused encoding: restart cleanly from IDLE.
        state_d = StIdle;
      end
    endcase
  end

  // State, PC, instruction latch and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      inst_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decoded purely from registered state; no input-to-output paths.
  always_comb begin
    imem_req = (state_q == StFetch);
    dmem_req = (state_q == StMem);
    dmem_we  = (state_q == StMem) & inst_q[22];
    alu_en   = (state_q == StExec);
    rf_we    = (state_q == StWb);
    fault    = (state_q == StFault);
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign state     = state_q;

`ifdef INST_SEQ_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic        retire;

  // A retire is any cycle that advances the PC to the next instruction.
  always_comb begin
    retire = (state_q == StWb) ||
             ((state_q == StExec) && (cls == ClsBranch)) ||
             ((state_q == StMem) && dmem_ack && inst_q[22]);
    retired_cnt_d = retire ? (retired_cnt_q + 32'd1) : retired_cnt_q;
  end

  // Retired-instruction counter; wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt_q <= '0;
    else     retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif

  // At most one request/strobe/fault indication is active in any cycle.
  strobe_onehot_a : assert property (@(posedge clk) disable iff (rst)
    $onehot0({imem_req, dmem_req, alu_en, rf_we, fault}));

  // The FSM never sits in the unused encoding.
  state_legal_a : assert property (@(posedge clk) disable iff (rst)
    state_q != 3'd6);

endmodule
